// File: rtl/dcache_nway.sv
// N-way set-associative, write-back, write-allocate data cache with multi-word lines.
// Combinational hit path toward the CPU; word-per-beat burst interface toward memory.
module dcache_nway #(
    parameter int XLEN           = 32,
    parameter int SETS           = 256,
    parameter int WAYS           = 2,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] A,
    input  logic [31:0]     WD,
    input  logic            WE,
    input  logic            RE,
    input  logic [2:0]      AddressingControl,
    output logic [31:0]     cache_dout,
    output logic            stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wd,
    input  logic [31:0]     mem_rd,
    input  logic            mem_ack
);
    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int SET_W  = $clog2(SETS);
    localparam int TAG_W  = XLEN - 2 - OFF_W - SET_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BEAT_W = (OFF_W > 0) ? OFF_W : 1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

    logic [31:0]      data_mem [SETS][WAYS][WORDS_PER_LINE];
    logic [TAG_W-1:0] tag_mem  [SETS][WAYS];
    logic [WAYS-1:0]  valid_q  [SETS];
    logic [WAYS-1:0]  dirty_q  [SETS];
    logic [WAY_W-1:0] rr_q     [SETS];

    state_t            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [WAY_W-1:0]  victim_q, victim_d;

    logic [TAG_W-1:0]  req_tag;
    logic [SET_W-1:0]  set_idx;
    logic [BEAT_W-1:0] word_idx;
    logic              access, hit, found, last_beat;
    logic [WAY_W-1:0]  hit_way, victim;
    logic              store_hit, refill_wr, refill_done;
    logic [31:0]       merged;

    assign req_tag = A[XLEN-1 -: TAG_W];
    assign set_idx = A[2+OFF_W +: SET_W];

    generate
        if (OFF_W > 0) begin : g_word
            assign word_idx = A[2 +: OFF_W];
        end else begin : g_single
            assign word_idx = '0;
        end
    endgenerate

    assign access    = RE | WE;
    assign last_beat = (beat_q == BEAT_W'(WORDS_PER_LINE - 1));

    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0]  t,
                                              input logic [SET_W-1:0]  s,
                                              input logic [BEAT_W-1:0] b);
        logic [31:0] a;
        a = 32'(t) << (2 + OFF_W + SET_W);
        a = a | (32'(s) << (2 + OFF_W));
        if (OFF_W > 0) a = a | (32'(b) << 2);
        return a;
    endfunction

    // SB replaces one byte, SH the half picked by A[1], anything else a full word.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [2:0] ac, input logic [1:0] bo);
        logic [31:0] r;
        r = old;
        case (ac)
            3'b000:  r[{bo, 3'b000} +: 8] = wd[7:0];
            3'b001:  if (bo[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        found   = 1'b0;
        victim  = rr_q[set_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[set_idx][w] && tag_mem[set_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!found && !valid_q[set_idx][w]) begin
                found  = 1'b1;
                victim = WAY_W'(w);
            end
        end
    end

    assign cache_dout = hit ? data_mem[set_idx][hit_way][word_idx] : 32'h0;
    assign merged     = merge(data_mem[set_idx][hit_way][word_idx], WD, AddressingControl, A[1:0]);

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        victim_d    = victim_q;
        stall       = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = A;
        mem_wd      = 32'h0;
        store_hit   = 1'b0;
        refill_wr   = 1'b0;
        refill_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (hit) begin
                        store_hit = WE;
                    end else begin
                        stall    = 1'b1;
                        victim_d = victim;
                        beat_d   = '0;
                        state_d  = (valid_q[set_idx][victim] && dirty_q[set_idx][victim])
                                   ? WRITEBACK : REFILL;
                    end
                end
            end
            WRITEBACK: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = line_addr(tag_mem[set_idx][victim_q], set_idx, beat_q);
                mem_wd   = data_mem[set_idx][victim_q][beat_q];
                if (mem_ack) begin
                    beat_d = last_beat ? '0 : beat_q + 1'b1;
                    if (last_beat) state_d = REFILL;
                end
            end
            REFILL: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = line_addr(req_tag, set_idx, beat_q);
                refill_wr = mem_ack;
                if (mem_ack) begin
                    beat_d = last_beat ? '0 : beat_q + 1'b1;
                    if (last_beat) begin
                        refill_done = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // NOTE: outputs are combinational, so reset must mask them directly to drop in the same cycle.
        if (rst) begin
            stall     = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = A;
            mem_wd    = 32'h0;
            store_hit = 1'b0;
        end
    end

    // NOTE: data and tag arrays carry no reset; valid bits make their contents irrelevant.
    always_ff @(posedge clk) begin
        if (refill_wr)   data_mem[set_idx][victim_q][beat_q] <= mem_rd;
        if (refill_done) tag_mem[set_idx][victim_q]          <= req_tag;
        if (store_hit)   data_mem[set_idx][hit_way][word_idx] <= merged;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            victim_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            victim_q <= victim_d;
            if (store_hit) dirty_q[set_idx][hit_way] <= 1'b1;
            if (refill_done) begin
                valid_q[set_idx][victim_q] <= 1'b1;
                dirty_q[set_idx][victim_q] <= 1'b0;
                rr_q[set_idx]              <= WAY_W'((int'(victim_q) + 1) % WAYS);
            end
        end
    end

endmodule

// File: tb/tb_dcache_nway.sv
// Scoreboard bench for dcache_nway: expected memory beats and load data are queued by
// the stimulus and consumed by independent memory-responder and load monitors.
module tb_dcache_nway;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A, WD;
    logic        WE, RE;
    logic [2:0]  AddressingControl;
    logic [31:0] cache_dout;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wd;
    logic [31:0] mem_rd  = 32'h0;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    dcache_nway dut (
        .clk(clk), .rst(rst), .A(A), .WD(WD), .WE(WE), .RE(RE),
        .AddressingControl(AddressingControl), .cache_dout(cache_dout), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd), .mem_ack(mem_ack)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } beat_t;

    beat_t       exp_beat[$];
    logic [31:0] exp_rd[$];
    logic [31:0] mem_model [logic [31:0]];
    int total = 0;
    int bad   = 0;
    int ack_delay = 0;
    int wait_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: checks every presented beat against the head of the queue.
    always @(negedge clk) begin
        if (!rst && mem_req) begin
            if (exp_beat.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got addr %h we %b expected no request", mem_addr, mem_we);
            end else begin
                check("beat_we", 32'(mem_we), 32'(exp_beat[0].we));
                check("beat_addr", mem_addr, exp_beat[0].addr);
                if (exp_beat[0].we) check("beat_wd", mem_wd, exp_beat[0].wd);
            end
            if (wait_cnt >= ack_delay) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
                if (mem_we) begin
                    mem_model[mem_addr] = mem_wd;
                    mem_rd = 32'h0;
                end else begin
                    mem_rd = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
                end
                if (exp_beat.size() > 0) void'(exp_beat.pop_front());
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    // Load monitor: a non-stalled load presents its data this cycle.
    always @(negedge clk) begin
        if (!rst && RE && !WE && !stall) begin
            if (exp_rd.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_load: got %h at %h expected no load", cache_dout, A);
            end else begin
                check($sformatf("load@%h", A), cache_dout, exp_rd.pop_front());
            end
        end
    end

    task automatic access(input logic we, input logic re, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] ac, input int exp_stall);
        int n;
        n = 0;
        @(posedge clk); #1;
        A = a; WD = wd; WE = we; RE = re; AddressingControl = ac;
        @(negedge clk);
        while (stall && n < 300) begin
            n++;
            @(negedge clk);
        end
        check($sformatf("stall_cycles@%h", a), 32'(n), 32'(exp_stall));
        @(posedge clk); #1;
        WE = 1'b0; RE = 1'b0;
    endtask

    task automatic lw(input logic [31:0] a, input logic [31:0] exp_data, input int exp_stall);
        exp_rd.push_back(exp_data);
        access(1'b0, 1'b1, a, 32'h0, 3'b010, exp_stall);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] ac,
                         input int exp_stall);
        access(1'b1, 1'b0, a, wd, ac, exp_stall);
    endtask

    task automatic exp_refill(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_beat.push_back('{1'b0, base + 32'(4 * i), 32'h0});
    endtask

    task automatic exp_wback(input logic [31:0] base, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        exp_beat.push_back('{1'b1, base,          w0});
        exp_beat.push_back('{1'b1, base + 32'h4,  w1});
        exp_beat.push_back('{1'b1, base + 32'h8,  w2});
        exp_beat.push_back('{1'b1, base + 32'hC,  w3});
    endtask

    initial begin
        int n;
        rst = 1'b1; A = 32'h1234; WD = 32'h0; WE = 1'b0; RE = 1'b0; AddressingControl = 3'b000;
        for (int i = 0; i < 4; i++) begin
            mem_model[32'h1000 + 32'(4 * i)] = 32'hA0 + 32'(i);
            mem_model[32'h2000 + 32'(4 * i)] = 32'hB0 + 32'(i);
            mem_model[32'h3000 + 32'(4 * i)] = 32'hC0 + 32'(i);
            mem_model[32'h4000 + 32'(4 * i)] = 32'hE0 + 32'(i);
            mem_model[32'h5000 + 32'(4 * i)] = 32'hD0 + 32'(i);
            mem_model[32'h6000 + 32'(4 * i)] = 32'h60 + 32'(i);
            mem_model[32'h7000 + 32'(4 * i)] = 32'h70 + 32'(i);
            mem_model[32'h8000 + 32'(4 * i)] = 32'h80 + 32'(i);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall",    32'(stall),   32'h0);
        check("rst_mem_req",  32'(mem_req), 32'h0);
        check("rst_mem_we",   32'(mem_we),  32'h0);
        check("rst_mem_wd",   mem_wd,       32'h0);
        check("rst_mem_addr", mem_addr,     32'h1234);
        check("rst_dout",     cache_dout,   32'h0);

        // Clean miss then hit in the same line
        exp_refill(32'h1000);
        lw(32'h1000, 32'hA0, 5);
        lw(32'h1008, 32'hA2, 0);

        // Store hits: word, byte, half
        store(32'h1000, 32'h11223344, 3'b010, 0);
        store(32'h1001, 32'h00000055, 3'b000, 0);
        lw(32'h1000, 32'h11225544, 0);
        store(32'h1002, 32'h0000BEEF, 3'b001, 0);
        lw(32'h1000, 32'hBEEF5544, 0);

        // Second way fill, then dirty eviction of way 0
        exp_refill(32'h2000);
        lw(32'h2000, 32'hB0, 5);
        exp_wback(32'h1000, 32'hBEEF5544, 32'hA1, 32'hA2, 32'hA3);
        exp_refill(32'h3000);
        lw(32'h3000, 32'hC0, 9);
        lw(32'h2000, 32'hB0, 0);

        // Slow memory: three wait cycles per beat
        ack_delay = 3;
        exp_refill(32'h5000);
        lw(32'h5000, 32'hD0, 17);
        lw(32'h500C, 32'hD3, 0);
        ack_delay = 0;

        // Write-allocate store miss, later written back on eviction
        exp_refill(32'h4000);
        store(32'h4000, 32'hDEADBEEF, 3'b010, 5);
        lw(32'h4000, 32'hDEADBEEF, 0);
        lw(32'h4004, 32'hE1, 0);
        exp_refill(32'h6000);
        lw(32'h6000, 32'h60, 5);
        exp_wback(32'h4000, 32'hDEADBEEF, 32'hE1, 32'hE2, 32'hE3);
        exp_refill(32'h7000);
        lw(32'h7000, 32'h70, 9);

        // Reset during refill beat 2
        ack_delay = 2;
        exp_refill(32'h8000);
        @(posedge clk); #1;
        A = 32'h8000; RE = 1'b1; AddressingControl = 3'b010;
        n = 0;
        @(negedge clk);
        while (!(mem_req && mem_addr == 32'h8008) && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("reach_beat2", 32'(n < 100), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("abort_mem_req", 32'(mem_req), 32'h0);
        check("abort_stall",   32'(stall),   32'h0);
        RE = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_beat.delete();
        ack_delay = 0;

        exp_refill(32'h8000);
        lw(32'h8000, 32'h80, 5);
        exp_refill(32'h1000);
        lw(32'h1000, 32'hBEEF5544, 5);

        repeat (2) @(posedge clk);
        check("beats_left", 32'(exp_beat.size()), 32'h0);
        check("loads_left", 32'(exp_rd.size()),   32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_nway.md
# dcache_nway

Parametrised N-way set-associative, write-back, write-allocate data cache with multi-word lines, sitting between the CPU load/store stage and main memory. CPU side: same-cycle combinational hit read, `stall` on miss. Memory side: word-per-beat burst handshake (`mem_req`/`mem_ack`) for dirty-line write-back and line refill. Replacement: first invalid way, else per-set round-robin.

## Interface
- `XLEN`, 32, address/data width (only 32 supported)
- `SETS`, 256, sets; power of two, ≥2
- `WAYS`, 2, ways per set; power of two, 1..8
- `WORDS_PER_LINE`, 4, 32-bit words per line; power of two, ≥1
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `A`  in  XLEN  byte address of access
- `WD`  in  32  store data (right-aligned)
- `WE`  in  1  store request
- `RE`  in  1  load request
- `AddressingControl`  in  3  store size: 000 SB, 001 SH, 010 SW, others = SW
- `cache_dout`  out  32  full hit word (CPU does extension)
- `stall`  out  1  CPU must hold `A`/`WD`/`WE`/`RE`/`AddressingControl` stable while high
- `mem_req`  out  1  memory beat request
- `mem_we`  out  1  1 = write beat, 0 = read beat
- `mem_addr`  out  32  word-aligned beat address
- `mem_wd`  out  32  write-beat data
- `mem_rd`  in  32  read-beat data, valid with `mem_ack`
- `mem_ack`  in  1  beat complete at this edge; ignored when `mem_req`=0

## Operation
- Address split: [1:0] byte, next log2(WORDS_PER_LINE) bits word, next log2(SETS) set, remainder tag.
- Per set per way: valid, dirty, tag, line data. Per set: round-robin pointer `rr` (log2(WAYS) bits).
- FSM states: IDLE, WRITEBACK, REFILL.
- IDLE, no access (`RE`=`WE`=0): `stall`=0, no state change.
- IDLE hit: `cache_dout` = hit word same cycle, `stall`=0. Store hit: merge at edge, set dirty. SB writes byte `A[1:0]`; SH writes half selected by `A[1]`; SW full word.
- IDLE miss: `stall`=1 combinationally. Victim = lowest-index invalid way, else `rr[set]`. Victim dirty → WRITEBACK; else → REFILL. Victim latched at transition.
- WRITEBACK: `mem_req`=1, `mem_we`=1, `mem_addr`={victim tag, set, beat, 00}, `mem_wd`=victim word[beat]. Beat advances on `mem_ack`; after last ack → REFILL, beat=0.
- REFILL: `mem_req`=1, `mem_we`=0, `mem_addr`={req tag, set, beat, 00}. On `mem_ack`, `mem_rd` → victim word[beat]. After last ack: tag written, valid=1, dirty=0, `rr[set]`=victim+1 mod WAYS → IDLE.
- Post-refill: access re-evaluates in IDLE as a hit (store miss = write-allocate; store lands on that hit cycle).
- `stall`=1 throughout WRITEBACK and REFILL.
- `RE` and `WE` both high: treated as store.
- `mem_addr`, `mem_we`, `mem_wd` stable while `mem_req`=1 and no ack.
- Inputs changing while `stall`=1: illegal; behaviour unspecified.

## Timing
- Reset (async): FSM=IDLE, beat=0, all valid/dirty/`rr` cleared; `mem_req`=0, `mem_we`=0, `stall`=0, `mem_addr`=A, `mem_wd`=0, `cache_dout`=0 when no hit. Data/tag arrays not reset.
- Reset mid-burst: `mem_req` drops in the same cycle. Partial line discarded. Dirty victim mid-writeback is lost. Memory must tolerate an aborted burst.
- Hit: 0-cycle latency.
- Clean miss, ack every cycle: `stall` high for 1 + WORDS_PER_LINE cycles (5 by default). Data valid on the following cycle with `stall`=0.
- Dirty miss: `stall` high for 1 + 2×WORDS_PER_LINE cycles (9 by default).
- Each extra ack wait cycle adds exactly one stall cycle.
- `WAYS`=1: `rr` unused; victim is always way 0.

## Test plan
Default parameters: tag A[31:12], set A[11:4], word A[3:2].
- Reset; LW 0x1000, memory returns 0xA0+beat with ack every cycle → read beats 0x1000/04/08/0C; `stall` high 5 cycles; then `cache_dout`=0xA0. LW 0x1008 → 0xA2, no stall, no `mem_req`.
- Line holds 0x11223344 at 0x1000; SB A=0x1001, WD=0x55 → word 0x11225544, no memory traffic. SH A=0x1002, WD=0xBEEF → 0xBEEF5544.
- Set 0: fill 0x1000 (way0), store there (dirty), fill 0x2000 (way1); LW 0x3000 → way0 evicted. 4 write beats 0x1000..0x100C with dirty data first, then 4 read beats 0x3000..; `stall` 9 cycles; re-LW 0x2000 hits.
- Ack delayed 3 cycles per beat on a clean refill → `mem_req`, `mem_addr` held; `stall` high 1+4×4=17 cycles; data correct.
- SW 0x4000 WD=0xDEADBEEF on a miss with a clean victim → refill only, then store; line dirty. LW 0x4000 → 0xDEADBEEF. Later eviction writes it back.
- Assert `rst` during REFILL beat 2 → `mem_req`=0 immediately, `stall`=0. Re-access of same address misses and refills fully.
